// File: rtl/rom_dl_router.sv
// ROM download router: steers ioctl bytes to a local BRAM strobe and to
// toggle-handshake SDRAM write ports, and stretches the core reset around downloads.
module rom_dl_router #(
    parameter int         NPORTS    = 2,
    parameter int         PACK16    = 0,
    parameter logic [7:0] LOCAL_TAG = 8'h00,
    parameter int         RST_HOLD  = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_downl,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              reset_req,
    output logic [NPORTS-1:0] port_req,
    input  logic [NPORTS-1:0] port_ack,
    output logic [22:0]       port_a,
    output logic [1:0]        port_ds,
    output logic [15:0]       port_d,
    output logic              port_we,
    output logic              local_wr,
    output logic [15:0]       local_addr,
    output logic [7:0]        local_data,
    output logic              overrun,
    output logic              rom_loaded,
    output logic              core_reset
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [NPORTS-1:0] req_q, req_d;
    logic [22:0]       a_q, a_d;
    logic [1:0]        ds_q, ds_d;
    logic [15:0]       d_q, d_d;
    logic              pend_q, pend_d;
    logic [22:0]       pendAddr_q, pendAddr_d;
    logic [7:0]        pendData_q, pendData_d;
    logic              hold_q, hold_d;
    logic [23:0]       holdAddr_q, holdAddr_d;
    logic [7:0]        holdData_q, holdData_d;
    logic              wr_q, downl_q, fell_q, fell_d;
    logic              localWr_q, localWr_d;
    logic [15:0]       localAddr_q, localAddr_d;
    logic [7:0]        localData_q, localData_d;
    logic              overrun_q, overrun_d;
    logic              loaded_q, loaded_d;
    logic              coreRst_q, coreRst_d;
    logic [7:0]        cnt_q, cnt_d;

    logic              byteEv, downlRise, downlFall, evValid, rstCond, unusedAddrMsb;
    logic [23:0]       evAddr;
    logic [7:0]        evData;

    assign byteEv        = ioctl_downl & ioctl_wr & ~wr_q;
    assign downlRise     = ioctl_downl & ~downl_q;
    assign downlFall     = ~ioctl_downl & downl_q;
    assign unusedAddrMsb = ioctl_addr[24];
    assign rstCond       = reset_req | ioctl_downl | ~loaded_q;

    // A byte parked behind a FLUSH is replayed in IDLE ahead of any live byte.
    assign evValid = hold_q | byteEv;
    assign evAddr  = hold_q ? holdAddr_q : ioctl_addr[23:0];
    assign evData  = hold_q ? holdData_q : ioctl_dout;

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        a_d        = a_q;
        ds_d       = ds_q;
        d_d        = d_q;
        pend_d     = pend_q;
        pendAddr_d = pendAddr_q;
        pendData_d = pendData_q;
        hold_d     = hold_q;
        holdAddr_d = holdAddr_q;
        holdData_d = holdData_q;
        case (state_q)
            IDLE: begin
                if (evValid) begin
                    hold_d = 1'b0;
                    if (PACK16 == 0) begin
                        a_d     = evAddr[23:1];
                        ds_d    = {evAddr[0], ~evAddr[0]};
                        d_d     = {evData, evData};
                        state_d = ISSUE;
                    end else if (pend_q && (!evAddr[0] || (evAddr[23:1] != pendAddr_q))) begin
                        hold_d     = 1'b1;
                        holdAddr_d = evAddr;
                        holdData_d = evData;
                        state_d    = FLUSH;
                    end else if (!evAddr[0]) begin
                        pend_d     = 1'b1;
                        pendAddr_d = evAddr[23:1];
                        pendData_d = evData;
                    end else if (pend_q) begin
                        a_d     = pendAddr_q;
                        ds_d    = 2'b11;
                        d_d     = {evData, pendData_q};
                        pend_d  = 1'b0;
                        state_d = ISSUE;
                    end else begin
                        a_d     = evAddr[23:1];
                        ds_d    = 2'b10;
                        d_d     = {evData, evData};
                        state_d = ISSUE;
                    end
                end else if (pend_q && !ioctl_downl) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                a_d     = pendAddr_q;
                ds_d    = 2'b01;
                d_d     = {pendData_q, pendData_q};
                pend_d  = 1'b0;
                state_d = ISSUE;
            end
            ISSUE: begin
                req_d   = ~req_q;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (port_ack == req_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Local strobe, overrun/loaded flags and the core reset stretcher.
    always_comb begin
        localWr_d   = byteEv && (ioctl_addr[23:16] == LOCAL_TAG);
        localAddr_d = localWr_d ? ioctl_addr[15:0] : localAddr_q;
        localData_d = localWr_d ? ioctl_dout : localData_q;
        overrun_d   = overrun_q;
        if (downlRise) begin
            overrun_d = 1'b0;
        end
        if (byteEv && ((state_q != IDLE) || hold_q)) begin
            overrun_d = 1'b1;
        end
        fell_d   = fell_q | downlFall;
        loaded_d = loaded_q | (!ioctl_downl && (state_q == IDLE) && !pend_q && !hold_q
                               && (fell_q || downlFall));
        if (rstCond) begin
            cnt_d     = 8'(RST_HOLD);
            coreRst_d = 1'b1;
        end else if (cnt_q != 8'd0) begin
            cnt_d     = cnt_q - 8'd1;
            coreRst_d = 1'b1;
        end else begin
            cnt_d     = cnt_q;
            coreRst_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            a_q         <= '0;
            ds_q        <= '0;
            d_q         <= '0;
            pend_q      <= 1'b0;
            pendAddr_q  <= '0;
            pendData_q  <= '0;
            hold_q      <= 1'b0;
            holdAddr_q  <= '0;
            holdData_q  <= '0;
            wr_q        <= 1'b0;
            downl_q     <= 1'b0;
            fell_q      <= 1'b0;
            localWr_q   <= 1'b0;
            localAddr_q <= '0;
            localData_q <= '0;
            overrun_q   <= 1'b0;
            loaded_q    <= 1'b0;
            coreRst_q   <= 1'b1;
            cnt_q       <= 8'(RST_HOLD);
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            a_q         <= a_d;
            ds_q        <= ds_d;
            d_q         <= d_d;
            pend_q      <= pend_d;
            pendAddr_q  <= pendAddr_d;
            pendData_q  <= pendData_d;
            hold_q      <= hold_d;
            holdAddr_q  <= holdAddr_d;
            holdData_q  <= holdData_d;
            wr_q        <= ioctl_wr;
            downl_q     <= ioctl_downl;
            fell_q      <= fell_d;
            localWr_q   <= localWr_d;
            localAddr_q <= localAddr_d;
            localData_q <= localData_d;
            overrun_q   <= overrun_d;
            loaded_q    <= loaded_d;
            coreRst_q   <= coreRst_d;
            cnt_q       <= cnt_d;
        end
    end

    assign port_req   = req_q;
    assign port_a     = a_q;
    assign port_ds    = ds_q;
    assign port_d     = d_q;
    assign port_we    = ioctl_downl | (state_q != IDLE);
    assign local_wr   = localWr_q;
    assign local_addr = localAddr_q;
    assign local_data = localData_q;
    assign overrun    = overrun_q;
    assign rom_loaded = loaded_q;
    assign core_reset = coreRst_q;
endmodule

// File: tb/tb_rom_dl_router.sv
// Bench for rom_dl_router: one byte-per-write instance and one 16-bit packing
// instance share the ioctl stimulus; each has its own ack responder and scoreboard.
module tb_rom_dl_router;
    typedef struct {
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
        logic [15:0] mask;
    } portExp_t;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } localExp_t;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        logic [22:0] expA;
        logic [1:0]  expDs;
        logic [15:0] expD;
        logic        isLocal;
    } vec_t;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        downl    = 1'b0;
    logic        wr       = 1'b0;
    logic [24:0] addr     = '0;
    logic [7:0]  dout     = '0;
    logic        resetReq = 1'b0;

    logic [1:0]  req0, req1;
    logic [1:0]  ack0 = '0, ack1 = '0;
    logic [22:0] portA0, portA1;
    logic [1:0]  portDs0, portDs1;
    logic [15:0] portD0, portD1;
    logic        portWe0, portWe1, localWr0, localWr1, overrun0, overrun1;
    logic        romLoaded0, romLoaded1, coreReset0, coreReset1;
    logic [15:0] localAddr0, localAddr1;
    logic [7:0]  localData0, localData1;

    int          vecCount  = 0;
    int          missCount = 0;
    logic        mon0En = 1'b0, mon1En = 1'b0;
    logic        ackHold0 = 1'b0, ackHold1 = 1'b0;
    int          ackCnt0 = 0, ackCnt1 = 0;
    int          ackDelay = 5;
    logic [1:0]  prevReq0 = '0, prevReq1 = '0;
    portExp_t    expQ0[$], expQ1[$];
    localExp_t   expL[$];
    portExp_t    pe0, pe1, pe;
    localExp_t   le;
    vec_t        vecs[5];
    int          highCount;
    int          guard;

    always #5 clk = ~clk;

    rom_dl_router #(.NPORTS(2), .PACK16(0), .LOCAL_TAG(8'h00), .RST_HOLD(16)) dut0 (
        .clk_sys(clk), .reset_n(reset_n), .ioctl_downl(downl), .ioctl_wr(wr),
        .ioctl_addr(addr), .ioctl_dout(dout), .reset_req(resetReq),
        .port_req(req0), .port_ack(ack0), .port_a(portA0), .port_ds(portDs0),
        .port_d(portD0), .port_we(portWe0), .local_wr(localWr0),
        .local_addr(localAddr0), .local_data(localData0), .overrun(overrun0),
        .rom_loaded(romLoaded0), .core_reset(coreReset0)
    );

    rom_dl_router #(.NPORTS(2), .PACK16(1), .LOCAL_TAG(8'h00), .RST_HOLD(16)) dut1 (
        .clk_sys(clk), .reset_n(reset_n), .ioctl_downl(downl), .ioctl_wr(wr),
        .ioctl_addr(addr), .ioctl_dout(dout), .reset_req(resetReq),
        .port_req(req1), .port_ack(ack1), .port_a(portA1), .port_ds(portDs1),
        .port_d(portD1), .port_we(portWe1), .local_wr(localWr1),
        .local_addr(localAddr1), .local_data(localData1), .overrun(overrun1),
        .rom_loaded(romLoaded1), .core_reset(coreReset1)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [24:0] a, input logic [7:0] b);
        @(posedge clk);
        #1;
        addr = a;
        dout = b;
        wr   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        wr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        mon0En   = 1'b0;
        mon1En   = 1'b0;
        ackHold0 = 1'b0;
        ackHold1 = 1'b0;
        wr       = 1'b0;
        downl    = 1'b0;
        resetReq = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        waitCycles(3);
        reset_n = 1'b1;
        waitCycles(1);
    endtask

    // Ack responders mirror port_req after ackDelay cycles unless held back.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack0    <= '0;
            ackCnt0 <= 0;
        end else if ((ack0 != req0) && !ackHold0) begin
            if (ackCnt0 == ackDelay - 1) begin
                ack0    <= req0;
                ackCnt0 <= 0;
            end else begin
                ackCnt0 <= ackCnt0 + 1;
            end
        end else begin
            ackCnt0 <= 0;
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack1    <= '0;
            ackCnt1 <= 0;
        end else if ((ack1 != req1) && !ackHold1) begin
            if (ackCnt1 == ackDelay - 1) begin
                ack1    <= req1;
                ackCnt1 <= 0;
            end else begin
                ackCnt1 <= ackCnt1 + 1;
            end
        end else begin
            ackCnt1 <= 0;
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            prevReq0 = '0;
        end else begin
            if (mon0En && (req0 != prevReq0)) begin
                if (expQ0.size() == 0) begin
                    vecCount++;
                    missCount++;
                    $display("[TB] FAIL req0_unexpected: got toggle to %0h, expected none", req0);
                end else begin
                    pe0 = expQ0.pop_front();
                    checkOutput("req0_a", 64'(portA0), 64'(pe0.a));
                    checkOutput("req0_ds", 64'(portDs0), 64'(pe0.ds));
                    checkOutput("req0_d", 64'(portD0 & pe0.mask), 64'(pe0.d & pe0.mask));
                end
            end
            prevReq0 = req0;
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            prevReq1 = '0;
        end else begin
            if (mon1En && (req1 != prevReq1)) begin
                if (expQ1.size() == 0) begin
                    vecCount++;
                    missCount++;
                    $display("[TB] FAIL req1_unexpected: got toggle to %0h, expected none", req1);
                end else begin
                    pe1 = expQ1.pop_front();
                    checkOutput("req1_a", 64'(portA1), 64'(pe1.a));
                    checkOutput("req1_ds", 64'(portDs1), 64'(pe1.ds));
                    checkOutput("req1_d", 64'(portD1 & pe1.mask), 64'(pe1.d & pe1.mask));
                end
            end
            prevReq1 = req1;
        end
    end

    always @(negedge clk) begin
        if (reset_n && mon0En && localWr0) begin
            if (expL.size() == 0) begin
                vecCount++;
                missCount++;
                $display("[TB] FAIL local_unexpected: got strobe at %0h, expected none", localAddr0);
            end else begin
                le = expL.pop_front();
                checkOutput("local_addr", 64'(localAddr0), 64'(le.addr));
                checkOutput("local_data", 64'(localData0), 64'(le.data));
            end
        end
    end

    initial begin
        vecs[0] = '{25'h0000003, 8'hA5, 23'h000001, 2'b10, 16'hA5A5, 1'b1};
        vecs[1] = '{25'h0010004, 8'h3C, 23'h008002, 2'b01, 16'h3C3C, 1'b0};
        vecs[2] = '{25'h1FFFFFE, 8'hC3, 23'h7FFFFF, 2'b01, 16'hC3C3, 1'b0};
        vecs[3] = '{25'h00000FF, 8'h7E, 23'h00007F, 2'b10, 16'h7E7E, 1'b1};
        vecs[4] = '{25'h000ABCD, 8'h5A, 23'h0055E6, 2'b10, 16'h5A5A, 1'b1};

        resetDut();
        checkOutput("rst_req", 64'(req0), 64'h0);
        checkOutput("rst_a", 64'(portA0), 64'h0);
        checkOutput("rst_ds", 64'(portDs0), 64'h0);
        checkOutput("rst_d", 64'(portD0), 64'h0);
        checkOutput("rst_local_wr", 64'(localWr0), 64'h0);
        checkOutput("rst_overrun", 64'(overrun0), 64'h0);
        checkOutput("rst_rom_loaded", 64'(romLoaded0), 64'h0);
        checkOutput("rst_core_reset", 64'(coreReset0), 64'h1);
        checkOutput("rst_port_we", 64'(portWe0), 64'h0);
        checkOutput("rst_core_reset1", 64'(coreReset1), 64'h1);

        // Byte-per-write table.
        mon0En = 1'b1;
        downl  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pe = '{vecs[i].expA, vecs[i].expDs, vecs[i].expD, 16'hFFFF};
            expQ0.push_back(pe);
            if (vecs[i].isLocal) begin
                le = '{vecs[i].addr[15:0], vecs[i].data};
                expL.push_back(le);
            end
            applyStimulus(vecs[i].addr, vecs[i].data);
            waitCycles(12);
            if (i == 0) begin
                checkOutput("req_first_toggle", 64'(req0), 64'h3);
            end
        end
        checkOutput("port_we_downl", 64'(portWe0), 64'h1);
        downl = 1'b0;
        waitCycles(3);
        checkOutput("rom_loaded_after_dl", 64'(romLoaded0), 64'h1);
        checkOutput("port_we_idle", 64'(portWe0), 64'h0);

        // Reset stretch after a one-cycle reset request.
        guard = 0;
        while (coreReset0 && guard < 60) begin
            waitCycles(1);
            guard++;
        end
        checkOutput("core_reset_released", 64'(coreReset0), 64'h0);
        @(posedge clk);
        #1 resetReq = 1'b1;
        @(posedge clk);
        #1 resetReq = 1'b0;
        highCount = 0;
        repeat (40) begin
            @(negedge clk);
            if (coreReset0) highCount++;
        end
        checkOutput("core_reset_width", 64'(highCount), 64'd17);
        checkOutput("q0_drained_a", 64'(expQ0.size()), 64'h0);
        checkOutput("ql_drained_a", 64'(expL.size()), 64'h0);

        // Overrun while an ack is withheld.
        resetDut();
        mon0En   = 1'b1;
        downl    = 1'b1;
        ackHold0 = 1'b1;
        pe = '{23'h000080, 2'b01, 16'h1111, 16'hFFFF};
        expQ0.push_back(pe);
        le = '{16'h0100, 8'h11};
        expL.push_back(le);
        applyStimulus(25'h0000100, 8'h11);
        le = '{16'h0102, 8'h22};
        expL.push_back(le);
        applyStimulus(25'h0000102, 8'h22);
        waitCycles(3);
        checkOutput("overrun_set", 64'(overrun0), 64'h1);
        checkOutput("overrun_req_once", 64'(req0), 64'h3);
        ackHold0 = 1'b0;
        waitCycles(12);
        checkOutput("overrun_sticky", 64'(overrun0), 64'h1);
        downl = 1'b0;
        waitCycles(3);
        downl = 1'b1;
        waitCycles(2);
        checkOutput("overrun_cleared", 64'(overrun0), 64'h0);
        downl = 1'b0;
        waitCycles(2);
        checkOutput("q0_drained_b", 64'(expQ0.size()), 64'h0);
        checkOutput("ql_drained_b", 64'(expL.size()), 64'h0);

        // Asynchronous reset while waiting for an ack.
        resetDut();
        mon0En   = 1'b1;
        downl    = 1'b1;
        ackHold0 = 1'b1;
        pe = '{23'h000002, 2'b10, 16'h4242, 16'hFFFF};
        expQ0.push_back(pe);
        le = '{16'h0005, 8'h42};
        expL.push_back(le);
        applyStimulus(25'h0000005, 8'h42);
        waitCycles(3);
        checkOutput("wait_req", 64'(req0), 64'h3);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("arst_req", 64'(req0), 64'h0);
        checkOutput("arst_a", 64'(portA0), 64'h0);
        checkOutput("arst_ds", 64'(portDs0), 64'h0);
        checkOutput("arst_d", 64'(portD0), 64'h0);
        checkOutput("arst_overrun", 64'(overrun0), 64'h0);
        checkOutput("arst_core_reset", 64'(coreReset0), 64'h1);
        downl = 1'b0;
        waitCycles(3);
        reset_n = 1'b1;
        ackHold0 = 1'b0;
        waitCycles(10);
        checkOutput("arst_no_toggle", 64'(req0), 64'h0);
        checkOutput("q0_drained_c", 64'(expQ0.size()), 64'h0);
        checkOutput("ql_drained_c", 64'(expL.size()), 64'h0);

        // 16-bit packing sequences.
        resetDut();
        mon1En = 1'b1;
        downl  = 1'b1;
        pe = '{23'h000008, 2'b11, 16'h3412, 16'hFFFF};
        expQ1.push_back(pe);
        applyStimulus(25'h0000010, 8'h12);
        checkOutput("pack_no_early_req", 64'(req1), 64'h0);
        applyStimulus(25'h0000011, 8'h34);
        waitCycles(12);
        pe = '{23'h000020, 2'b01, 16'h0066, 16'h00FF};
        expQ1.push_back(pe);
        pe = '{23'h000028, 2'b10, 16'h7700, 16'hFF00};
        expQ1.push_back(pe);
        applyStimulus(25'h0000040, 8'h66);
        applyStimulus(25'h0000051, 8'h77);
        waitCycles(25);
        pe = '{23'h000030, 2'b01, 16'h0088, 16'h00FF};
        expQ1.push_back(pe);
        pe = '{23'h000031, 2'b11, 16'h9A99, 16'hFFFF};
        expQ1.push_back(pe);
        applyStimulus(25'h0000060, 8'h88);
        applyStimulus(25'h0000062, 8'h99);
        waitCycles(20);
        applyStimulus(25'h0000063, 8'h9A);
        waitCycles(12);
        checkOutput("pack_overrun_clear", 64'(overrun1), 64'h0);

        ackHold1 = 1'b1;
        pe = '{23'h000010, 2'b01, 16'h0055, 16'h00FF};
        expQ1.push_back(pe);
        applyStimulus(25'h0000020, 8'h55);
        waitCycles(2);
        downl = 1'b0;
        waitCycles(10);
        checkOutput("flush_rom_not_loaded", 64'(romLoaded1), 64'h0);
        ackHold1 = 1'b0;
        waitCycles(12);
        checkOutput("flush_rom_loaded", 64'(romLoaded1), 64'h1);
        checkOutput("q1_drained", 64'(expQ1.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule
